game_key_ctrl: RTL
==================

// Module: game_key_ctrl
// PURPOSE
//  Parametrised successor to the single-key start detector. Decodes PS/2 scan codes into game commands:
//  start, pause/resume, quit and a latched direction. Suppresses typematic repeats and tracks held keys.
//  Runs a small game-state FSM. Sits between the PS/2 keyboard receiver and the game core / VGA logic.
// PARAMETERS
//  KEY_START   8'h29  scan code for start (Space)
//  KEY_PAUSE   8'h4D  scan code for pause/resume (P)
//  KEY_QUIT    8'h76  scan code for quit (Esc)
//  KEY_UP/DOWN/LEFT/RIGHT  8'h75/8'h72/8'h6B/8'h74  arrow scan codes
//  ARROW_EXT   1      1: arrow codes match only with ext=1
//  REPEAT_FILT 1      1: a make for an already-held key is not a press
//  REVERSE_EN  1      0: a press opposite to the current dir is ignored
//  DIR_INIT    2'd3   dir loaded at reset and on each start (RIGHT)
// PORTS
//  clk        in   1  system clock
//  rst        in   1  asynchronous, active-high reset
//  key_valid  in   1  one-cycle strobe: keycode/make/ext are a new event
//  keycode    in   8  scan code (ext prefix stripped)
//  ext        in   1  event carried E0 prefix
//  make       in   1  1=make (press), 0=break (release)
//  game_over  in   1  level/pulse from game core: return to IDLE
//  startGame  out  1  one-cycle pulse on IDLE->PLAYING
//  quit       out  1  one-cycle pulse on quit to IDLE
//  paused     out  1  high while in PAUSED
//  playing    out  1  high while in PLAYING
//  dir        out  2  UP=0 DOWN=1 LEFT=2 RIGHT=3, latched
//  held       out  7  held bitmap {RIGHT,LEFT,DOWN,UP,QUIT,PAUSE,START}
// BEHAVIOUR
//  - Reset (async): state=IDLE, startGame=quit=paused=playing=0, dir=DIR_INIT, held=0.
//  - All outputs registered. Latency is 1 clk from the key_valid cycle to the output change or pulse.
//  - Inputs are ignored when key_valid=0.
//  - Match rule: arrows need ext==ARROW_EXT. START/PAUSE/QUIT need ext=0.
//  - held[i]: set on a matching make; cleared on a matching break. Unmatched codes change nothing.
//  - Press: a matching make. With REPEAT_FILT=1, it is a press only if held[i] was 0 that cycle.
//  - FSM transitions:
//      IDLE:    START press -> PLAYING; startGame=1; dir<=DIR_INIT.
//      PLAYING: PAUSE -> PAUSED; QUIT -> IDLE with quit=1; game_over -> IDLE, no quit pulse.
//      PAUSED:  PAUSE or START -> PLAYING, no startGame; QUIT -> IDLE with quit=1;
//               game_over -> IDLE.
//  - Priority in one cycle: game_over > QUIT > PAUSE/START. A press in that cycle still updates held.
//  - Direction presses update dir only in PLAYING. They are ignored in IDLE/PAUSED.
//    With REVERSE_EN=0, the opposite direction (dir^2'b01 within a pair) is ignored.
//  - Break events never change state or dir. Pulses are never longer than 1 cycle.
//  - Reset mid-game: immediate return to IDLE. dir=DIR_INIT.
// STRUCTURE
//  - Shared include/package game_keys_pkg: scan code constants, state encoding
//    (IDLE=0, PLAYING=1, PAUSED=2), dir encoding, held bit indices.
//  - Sub-module key_event_filter: key match, held bitmap, repeat filter, 7-bit press vector.
//  - Top level: FSM, dir latch, pulse registers.
// TESTING
//  1 rst, then Space make (29,ext0) -> startGame=1 for exactly 1 clk next cycle; playing=1; dir=3.
//  2 Space make x3 with no break (REPEAT_FILT=1) in PLAYING -> no state change; held[0]=1;
//    then break -> held[0]=0.
//  3 PLAYING: P make -> paused=1; E0 75 make while paused -> dir stays 3;
//    P break, P make -> playing=1, no startGame pulse.
//  4 PLAYING dir=3, REVERSE_EN=0: E0 6B make -> dir=3; E0 75 make -> dir=0;
//    75 make with ext=0 -> dir unchanged.
//  5 PLAYING: Esc make and game_over in the same cycle -> IDLE, quit=0.
//    Later Esc in PAUSED -> quit pulse, IDLE.
//  6 assert rst mid-PLAYING with dir=0 and keys held -> all outputs at reset values asynchronously.

Source files
------------

// File: rtl/game_keys_pkg.sv
// Shared definitions for the game key controller: scan codes, game state
// encoding, direction encoding and held-bitmap bit positions.
package game_keys_pkg;

    // Default PS/2 set-2 scan codes (E0 prefix already stripped for arrows)
    localparam logic [7:0] SC_SPACE = 8'h29;
    localparam logic [7:0] SC_P     = 8'h4D;
    localparam logic [7:0] SC_ESC   = 8'h76;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;

    // Game state encoding
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PLAYING = 2'd1,
        ST_PAUSED  = 2'd2
    } game_state_t;

    // Direction encoding; opposite pairs differ only in bit 0
    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    // Bit positions in the held / press vectors
    localparam int HB_START = 0;
    localparam int HB_PAUSE = 1;
    localparam int HB_QUIT  = 2;
    localparam int HB_UP    = 3;
    localparam int HB_DOWN  = 4;
    localparam int HB_LEFT  = 5;
    localparam int HB_RIGHT = 6;
    localparam int NUM_KEYS = 7;

    // The direction that would reverse the snake/player onto itself
    function automatic logic [1:0] oppositeDir(input logic [1:0] d);
        return d ^ 2'b01;
    endfunction

endpackage

// File: rtl/key_event_filter.sv
// Matches incoming key events against the command keys, tracks which keys
// are currently held down and produces a one-hot-per-key press vector with
// optional typematic repeat suppression.
module key_event_filter
    import game_keys_pkg::*;
#(
    parameter logic [7:0] KEY_START   = SC_SPACE,
    parameter logic [7:0] KEY_PAUSE   = SC_P,
    parameter logic [7:0] KEY_QUIT    = SC_ESC,
    parameter logic [7:0] KEY_UP      = SC_UP,
    parameter logic [7:0] KEY_DOWN    = SC_DOWN,
    parameter logic [7:0] KEY_LEFT    = SC_LEFT,
    parameter logic [7:0] KEY_RIGHT   = SC_RIGHT,
    parameter bit         ARROW_EXT   = 1'b1,
    parameter bit         REPEAT_FILT = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_key_valid,
    input  logic [7:0]          i_keycode,
    input  logic                i_ext,
    input  logic                i_make,
    output logic [NUM_KEYS-1:0] o_held,
    output logic [NUM_KEYS-1:0] o_press
);

    logic [NUM_KEYS-1:0] r_held;
    logic [NUM_KEYS-1:0] w_match;
    logic [NUM_KEYS-1:0] w_notHeld;

    // Decode which command key this event refers to (command keys need no E0)
    always_comb begin
        w_match           = '0;
        w_match[HB_START] = (i_keycode == KEY_START) && !i_ext;
        w_match[HB_PAUSE] = (i_keycode == KEY_PAUSE) && !i_ext;
        w_match[HB_QUIT]  = (i_keycode == KEY_QUIT)  && !i_ext;
        w_match[HB_UP]    = (i_keycode == KEY_UP)    && (i_ext == ARROW_EXT);
        w_match[HB_DOWN]  = (i_keycode == KEY_DOWN)  && (i_ext == ARROW_EXT);
        w_match[HB_LEFT]  = (i_keycode == KEY_LEFT)  && (i_ext == ARROW_EXT);
        w_match[HB_RIGHT] = (i_keycode == KEY_RIGHT) && (i_ext == ARROW_EXT);
    end

    // A make is a fresh press unless the key is already down and repeats are filtered
    always_comb begin
        w_notHeld = REPEAT_FILT ? ~r_held : '1;
        o_press   = '0;
        if (i_key_valid && i_make) begin
            o_press = w_match & w_notHeld;
        end
    end

    // Held bitmap: set on a matching make, cleared on a matching break
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_held <= '0;
        end else if (i_key_valid) begin
            if (i_make) begin
                r_held <= r_held | w_match;
            end else begin
                r_held <= r_held & ~w_match;
            end
        end
    end

    assign o_held = r_held;

endmodule

// File: rtl/game_key_ctrl.sv
// Keyboard-to-game command decoder: runs the IDLE/PLAYING/PAUSED state
// machine, latches the movement direction and generates start/quit pulses.
// All outputs are registered, one clock after the key event.
module game_key_ctrl
    import game_keys_pkg::*;
#(
    parameter logic [7:0] KEY_START   = SC_SPACE,
    parameter logic [7:0] KEY_PAUSE   = SC_P,
    parameter logic [7:0] KEY_QUIT    = SC_ESC,
    parameter logic [7:0] KEY_UP      = SC_UP,
    parameter logic [7:0] KEY_DOWN    = SC_DOWN,
    parameter logic [7:0] KEY_LEFT    = SC_LEFT,
    parameter logic [7:0] KEY_RIGHT   = SC_RIGHT,
    parameter bit         ARROW_EXT   = 1'b1,
    parameter bit         REPEAT_FILT = 1'b1,
    parameter bit         REVERSE_EN  = 1'b1,
    parameter logic [1:0] DIR_INIT    = DIR_RIGHT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                key_valid,
    input  logic [7:0]          keycode,
    input  logic                ext,
    input  logic                make,
    input  logic                game_over,
    output logic                startGame,
    output logic                quit,
    output logic                paused,
    output logic                playing,
    output logic [1:0]          dir,
    output logic [NUM_KEYS-1:0] held
);

    game_state_t         r_state;
    game_state_t         w_stateNext;
    logic                r_startGame;
    logic                r_quit;
    logic                r_paused;
    logic                r_playing;
    logic [1:0]          r_dir;
    logic                w_startNext;
    logic                w_quitNext;
    logic [1:0]          w_dirNext;
    logic [1:0]          w_dirCand;
    logic                w_dirHit;
    logic [NUM_KEYS-1:0] w_press;

    key_event_filter #(
        .KEY_START   (KEY_START),
        .KEY_PAUSE   (KEY_PAUSE),
        .KEY_QUIT    (KEY_QUIT),
        .KEY_UP      (KEY_UP),
        .KEY_DOWN    (KEY_DOWN),
        .KEY_LEFT    (KEY_LEFT),
        .KEY_RIGHT   (KEY_RIGHT),
        .ARROW_EXT   (ARROW_EXT),
        .REPEAT_FILT (REPEAT_FILT)
    ) u_filter (
        .clk         (clk),
        .rst         (rst),
        .i_key_valid (key_valid),
        .i_keycode   (keycode),
        .i_ext       (ext),
        .i_make      (make),
        .o_held      (held),
        .o_press     (w_press)
    );

    // Game state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next-state and pulse decode; game_over beats quit, which beats pause/start
    always_comb begin
        w_stateNext = r_state;
        w_startNext = 1'b0;
        w_quitNext  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_press[HB_START]) begin
                    w_stateNext = ST_PLAYING;
                    w_startNext = 1'b1;
                end
            end
            ST_PLAYING: begin
                if (game_over) begin
                    w_stateNext = ST_IDLE;
                end else if (w_press[HB_QUIT]) begin
                    w_stateNext = ST_IDLE;
                    w_quitNext  = 1'b1;
                end else if (w_press[HB_PAUSE]) begin
                    w_stateNext = ST_PAUSED;
                end
            end
            ST_PAUSED: begin
                if (game_over) begin
                    w_stateNext = ST_IDLE;
                end else if (w_press[HB_QUIT]) begin
                    w_stateNext = ST_IDLE;
                    w_quitNext  = 1'b1;
                end else if (w_press[HB_PAUSE] || w_press[HB_START]) begin
                    w_stateNext = ST_PLAYING;
                end
            end
            default: begin
                w_stateNext = ST_IDLE;
            end
        endcase
    end

    // Pick the pressed arrow (if any); a single event carries at most one code
    always_comb begin
        w_dirCand = r_dir;
        w_dirHit  = 1'b0;
        if (w_press[HB_UP]) begin
            w_dirCand = DIR_UP;
            w_dirHit  = 1'b1;
        end else if (w_press[HB_DOWN]) begin
            w_dirCand = DIR_DOWN;
            w_dirHit  = 1'b1;
        end else if (w_press[HB_LEFT]) begin
            w_dirCand = DIR_LEFT;
            w_dirHit  = 1'b1;
        end else if (w_press[HB_RIGHT]) begin
            w_dirCand = DIR_RIGHT;
            w_dirHit  = 1'b1;
        end
    end

    // Direction update: reload on start, steer only while playing, optionally block reversal
    always_comb begin
        w_dirNext = r_dir;
        if (w_startNext) begin
            w_dirNext = DIR_INIT;
        end else if (r_state == ST_PLAYING && w_dirHit) begin
            if (REVERSE_EN || (w_dirCand != oppositeDir(r_dir))) begin
                w_dirNext = w_dirCand;
            end
        end
    end

    // Registered outputs: status flags, one-cycle pulses and the direction latch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_startGame <= 1'b0;
            r_quit      <= 1'b0;
            r_paused    <= 1'b0;
            r_playing   <= 1'b0;
            r_dir       <= DIR_INIT;
        end else begin
            r_startGame <= w_startNext;
            r_quit      <= w_quitNext;
            r_paused    <= (w_stateNext == ST_PAUSED);
            r_playing   <= (w_stateNext == ST_PLAYING);
            r_dir       <= w_dirNext;
        end
    end

    assign startGame = r_startGame;
    assign quit      = r_quit;
    assign paused    = r_paused;
    assign playing   = r_playing;
    assign dir       = r_dir;

endmodule
